// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle variable right shifter, one power-of-two stage per clock
//
// Purpose: applies right-shift stages 2**(STAGES-1) .. 1 to a shared data
// register, one stage per clock, MSB stage first. It trades latency for area
// compared with a combinational barrel shifter.
//
// Optional feature: define SHIFT_ARITH_EN to add the `arith` input and the
// sign-fill path. Without it, every shift is logical with zero fill.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   start   - request, sampled only in IDLE or DONE
//   a       - operand, captured on the accepting edge
//   amt     - shift amount, captured on the accepting edge
//   arith   - (SHIFT_ARITH_EN only) 1 = arithmetic, 0 = logical shift
//   busy    - high while stages are being applied
//   done    - one-cycle pulse; result is final in that cycle
//   result  - the data register; intermediate values show while busy
module shift_sequencer #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [STAGES-1:0] amt,
`ifdef SHIFT_ARITH_EN
  input  logic              arith,
`endif
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result
);

  localparam int CW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [STAGES:0] SH_ONE = 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(STAGES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [STAGES-1:0] amt_q, amt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [STAGES:0]   sh;
  logic [WIDTH-1:0]  shifted;
`ifdef SHIFT_ARITH_EN
  logic              arith_q, arith_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      cnt_q   <= '0;
`ifdef SHIFT_ARITH_EN
      arith_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      cnt_q   <= cnt_d;
`ifdef SHIFT_ARITH_EN
      arith_q <= arith_d;
`endif
    end
  end

  // Current stage distance and the shifted data for it. In an arithmetic
  // shift the MSB never changes, so it is the operand sign on every stage.
  always_comb begin
    sh      = SH_ONE << cnt_q;
    shifted = data_q >> sh;
`ifdef SHIFT_ARITH_EN
    if (arith_q && data_q[WIDTH-1]) begin
      shifted = shifted | ~({WIDTH{1'b1}} >> sh);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    cnt_d   = cnt_q;
`ifdef SHIFT_ARITH_EN
    arith_d = arith_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          data_d  = a;
          amt_d   = amt;
          cnt_d   = CNT_LAST;
`ifdef SHIFT_ARITH_EN
          arith_d = arith;
`endif
          state_d = SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (amt_q[cnt_q]) begin
          data_d = shifted;
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [4:0]  amt = '0;
  logic        arith_r = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(32), .STAGES(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .amt    (amt),
`ifdef SHIFT_ARITH_EN
    .arith  (arith_r),
`endif
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] av, input logic [4:0] sv, input logic ar);
    logic [31:0] r;
    r = av;
    for (int i = 0; i < sv; i++) r = {ar & av[31], r[31:1]};
    return r;
  endfunction

  // Called at a negedge; drives a request and follows it to done.
  task automatic run_op(input logic [31:0] av, input logic [4:0] sv, input logic ar, input string tag);
    int cyc;
    int busy_cnt;
    bit seen;
    logic [31:0] exp;
    start = 1'b1; a = av; amt = sv; arith_r = ar;
    sb.push_back(model(av, sv, ar));
    cyc = 0; busy_cnt = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) seen = 1;
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " latency"}, 32'(cyc), 32'd6);
      check({tag, " busy cycles"}, 32'(busy_cnt), 32'd5);
      exp = sb.pop_front();
      check({tag, " result"}, result, exp);
      @(negedge clk);
      check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    end else begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int dones;
    logic [31:0] cap;
    logic [31:0] exp;

    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;

    // start on the first edge after reset release
    run_op(32'hF000_0000, 5'd4, 1'b0, "lsr4");
    run_op(32'h8000_0000, 5'd31, 1'b0, "lsr31");
    run_op(32'h1234_5678, 5'd0, 1'b0, "amt0");
`ifdef SHIFT_ARITH_EN
    run_op(32'hF000_0000, 5'd4, 1'b1, "asr4");
    run_op(32'hF000_0000, 5'd31, 1'b1, "asr31");
    run_op(32'h7000_0000, 5'd4, 1'b1, "asr_pos");
`endif

    // start pulsed mid-SHIFT is ignored
    start = 1'b1; a = 32'hFFFF_0000; amt = 5'd8; arith_r = 1'b0;
    sb.push_back(32'h00FF_FF00);
    dones = 0; cap = '0; cyc = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = (i == 2);
      if (i == 2) begin a = 32'h0000_0001; amt = 5'd1; end
      if (done === 1'b1) begin dones++; cap = result; cyc = i; end
    end
    exp = sb.pop_front();
    check("mid start done count", 32'(dones), 32'd1);
    check("mid start latency", 32'(cyc), 32'd6);
    check("mid start result", cap, exp);

    // start held through DONE: back-to-back acceptance
    start = 1'b1; a = 32'hFFFF_FFFF; amt = 5'd16;
    sb.push_back(32'h0000_FFFF);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    check("b2b first latency", 32'(cyc), 32'd6);
    exp = sb.pop_front();
    check("b2b first result", result, exp);
    a = 32'h0000_00F0; amt = 5'd4;
    sb.push_back(32'h0000_000F);
    cyc = 0;
    do begin @(negedge clk); start = 1'b0; cyc++; end while (done !== 1'b1 && cyc < 20);
    check("b2b second latency", 32'(cyc), 32'd6);
    exp = sb.pop_front();
    check("b2b second result", result, exp);
    @(negedge clk);

    // reset asserted at E3 aborts the operation
    start = 1'b1; a = 32'hF0F0_F0F0; amt = 5'd1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort result", result, 32'd0);
    dones = 0;
    repeat (8) begin @(negedge clk); if (done === 1'b1) dones++; end
    check("abort no done", 32'(dones), 32'd0);
    rst = 1'b0;
    run_op(32'hDEAD_BEEF, 5'd12, 1'b0, "after reset");

    for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARITH_EN
      run_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), "random");
`else
      run_op($urandom, 5'($urandom_range(0, 31)), 1'b0, "random");
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle variable right shifter. It sequences the fixed power-of-two right-shift stages (16, 8, 4, 2, 1) over a single shared 32-bit data register, applying one stage per clock. It accepts an operand and a 5-bit shift amount through a start/busy/done handshake. It sits between the ALU issue logic and the shift datapath, replacing a full combinational barrel shifter where area matters more than latency.

## Interface
- `WIDTH`, 32: operand and result width. Must equal 2**`STAGES`.
- `STAGES`, 5: number of shift stages and width of `amt`.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only when the block can accept (IDLE or DONE).
- `a` input `WIDTH`: operand; captured on the accepting edge.
- `amt` input `STAGES`: shift amount, 0..31; captured on the accepting edge.
- `arith` input 1: present only with `SHIFT_ARITH_EN`. 1 = arithmetic shift, 0 = logical. Captured on the accepting edge.
- `busy` output 1: high while stages are being applied.
- `done` output 1: one-cycle pulse; `result` is final in that cycle.
- `result` output `WIDTH`: shift result; holds its value until the next accepted start.

## Operation
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE + `start`:
  - Load data register <= `a`, amount register <= `amt`, stage counter <= `STAGES`-1.
  - Go to SHIFT.
- SHIFT, one edge per stage, stage index k = counter value (4 down to 0, MSB first):
  - If amount bit k = 1: data <= data >> (1<<k), filling vacated bits with the fill bit.
  - If amount bit k = 0: data unchanged.
  - Counter decrements each edge. The edge that processes k=0 moves the state to DONE.
- Fill bit: 0 for a logical shift. For an arithmetic shift it is the data MSB, which equals the operand sign throughout.
- DONE:
  - `done`=1 for exactly one cycle.
  - Next edge: go to IDLE, or, if `start`=1, accept the new request directly (back-to-back) and go to SHIFT.
- `start` during SHIFT is ignored; there is no queueing.
- `amt`=0 still takes the full pass; latency is fixed and data-independent.
- `result` is the data register itself. During SHIFT it shows intermediate values; consumers must qualify with `done`.

## Timing
- Accept edge E0. Stages 16/8/4/2/1 are applied on edges E1..E5.
- `done`=1 in the cycle after E5; it deasserts at E6.
- Fixed latency: 6 cycles from accept to `done` high. Throughput: one operation per 6 cycles with back-to-back starts.
- `busy`=1 from after E0 through E5, i.e. exactly 5 cycles. `busy`=0 in IDLE and DONE.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter=0.
- Reset asserted mid-operation aborts immediately. No `done` is produced; `result` returns to 0.
- `start` on the first edge after reset deassertion is accepted normally.

## Configuration
- `SHIFT_ARITH_EN` defined:
  - `arith` port exists and is latched at accept.
  - `arith`=1 selects sign fill; `arith`=0 selects zero fill.
- `SHIFT_ARITH_EN` undefined:
  - `arith` port is absent. All shifts are logical with zero fill.
  - No sign-fill logic is synthesized.

## Test plan
- `a`=0xF000_0000, `amt`=4, logical → `busy` high for 5 cycles; `done` 6 cycles after accept with `result`=0x0F00_0000.
- With `SHIFT_ARITH_EN`: `a`=0xF000_0000, `amt`=4, `arith`=1 → `result`=0xFF00_0000. Same operand with `amt`=31 → 0xFFFF_FFFF.
- `a`=0x8000_0000, `amt`=31 → `result`=0x0000_0001. `a`=0x1234_5678, `amt`=0 → `result`=0x1234_5678, with `done` still at 6 cycles.
- `start` pulsed mid-SHIFT with a different operand → ignored; first result unaffected; exactly one `done`.
- `start` held high through DONE:
  - First request is `a`=0xFFFF_FFFF, `amt`=16 → 0x0000_FFFF.
  - Second request is accepted on the DONE edge: `a`=0x0000_00F0, `amt`=4 → 0x0000_000F, `done` 6 cycles later.
- `rst` asserted at E3 → all outputs reset immediately, no `done`. A new start after release completes normally.
